writeback: RTL and testbench
============================

Name: writeback

Overview:
- Retire stage of the tiny86 execute path, directly downstream of the execute units (meta, ALU, etc.).
- Accepts one execute result per handshake into a 2-entry skid buffer.
- Commits results in order to the GPR write port and the 7-bit compressed architectural status register.
- Builds the LAHF byte from status at commit, so execute units only raise ah_wr.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept a result this cycle.
- in_reg_idx  in  3  destination GPR (0 = EAX).
- in_reg_wr  in  1  result targets a GPR.
- in_lane  in  2  0 = dword, 1 = word [15:0], 2 = byte [7:0], 3 = high byte [15:8].
- in_result  in  32  result value, right-aligned for byte/word lanes.
- in_ah_wr  in  1  LAHF; overrides in_reg_idx, in_reg_wr and in_lane.
- in_status  in  7  status produced by the instruction: {DF,AF,CF,PF,ZF,SF,OF}, bit 6..0.
- in_status_wr  in  1  commit in_status.
- rf_stall  in  1  register file cannot accept a write this cycle.
- rf_wr_en  out  1  GPR write strobe.
- rf_wr_idx  out  3  GPR index.
- rf_wr_be  out  4  byte enables.
- rf_wr_data  out  32  lane-aligned write data.
- status_q  out  7  architectural status.
- status_fwd  out  7  status for the next instruction to execute.
- retire_cnt  out  CNT_W  instructions retired.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - Buffer empty; in_ready = 1.
  - rf_wr_en = 0, rf_wr_idx = 0, rf_wr_be = 0, rf_wr_data = 0.
  - status_q = 0, status_fwd = 0, retire_cnt = 0.
- Reset mid-operation discards all buffered entries; nothing further is committed.
- Occupancy FSM with states EMPTY, ONE, TWO:
  - Accept = in_valid & in_ready, with in_ready = (state != TWO).
  - Commit = (state != EMPTY) & !rf_stall, taken from the head entry.
  - Accept and commit together leave the state unchanged; in ONE, the new entry becomes head.
  - Accept without commit moves EMPTY→ONE or ONE→TWO.
  - Commit without accept moves TWO→ONE or ONE→EMPTY.
  - A valid input seen in TWO is not taken (in_ready = 0); the producer holds its data until accepted.
- Latency: a result accepted at edge N drives rf_wr_* during cycle N+1 at the earliest. Its status is visible on status_q after edge N+1.
- rf_wr_* are combinational from the head entry and gated by commit. rf_wr_en = commit & (reg_wr | ah_wr).
- Lane mapping:
  - dword: be 1111, data = result.
  - word: be 0011, data = {16'b0, result[15:0]}.
  - byte: be 0001, data = {24'b0, result[7:0]}.
  - high byte: be 0010, data = {16'b0, result[7:0], 8'b0}.
- ah_wr: idx 0, be 0010, data[15:8] = {SF,ZF,0,AF,0,PF,1,CF}, taken from the entry's in_status. DF and OF are not placed in AH.
- status_q <= head status on commit when the head has status_wr set.
- retire_cnt increments on every commit, wrapping at 2^CNT_W.
- Entries with neither reg_wr nor ah_wr still retire; they update status only.

Optional Feature:
- Macro: WB_STATUS_FWD_EN.
- Defined: status_fwd is the status of the youngest buffered entry with status_wr set, else status_q. Back-to-back flag consumers then see pending flags.
- Undefined: status_fwd = status_q. in_ready is additionally forced to 0 whenever any buffered entry has status_wr set, which serialises flag producers.

Decomposition:
- defines.v holds: STAT_* bit positions, EFLAGS_* positions, new WB_LANE_DWORD/WORD/BYTE/HBYTE codes, and the LAHF constant bit positions.
- One sub-module, wb_skid_buf: the 2-entry FIFO plus occupancy FSM, payload width as a parameter.
- writeback contains the lane/LAHF formatting, status register and counter.

Test Plan:
- Reset then single dword write: idx 3, result 0xDEADBEEF → next cycle rf_wr_en = 1, be 1111, data 0xDEADBEEF; retire_cnt = 1.
- LAHF with in_status 7'b0011110 (CF, PF, ZF, SF set) → idx 0, be 0010, data 0x0000C700.
- High-byte lane, result 0x5A → be 0010, data 0x00005A00; status_q unchanged when status_wr = 0.
- rf_stall held high for 3 cycles while 3 results are offered:
  - Two are accepted and in_ready drops.
  - After the stall releases, commits occur in order and the third is accepted.
- Assert rst while in TWO → rf_wr_en = 0 immediately, status_q = 0, retire_cnt = 0, in_ready = 1.
- With WB_STATUS_FWD_EN: a CLC-style entry (status 0x00, status_wr) buffered behind a stall → status_fwd = 0x00 before status_q changes. Without the macro, in_ready = 0 until that entry commits.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
// Contents: status/EFLAGS bit positions, lane codes, the buffered entry
// layout, the skid-buffer occupancy states and the LAHF byte builder.
package writeback_pkg;

  // Compressed 7-bit status register layout {DF,AF,CF,PF,ZF,SF,OF}.
  localparam int STAT_W  = 7;
  localparam int STAT_OF = 0;
  localparam int STAT_SF = 1;
  localparam int STAT_ZF = 2;
  localparam int STAT_PF = 3;
  localparam int STAT_CF = 4;
  localparam int STAT_AF = 5;
  localparam int STAT_DF = 6;

  // Architectural EFLAGS positions; the low byte doubles as the AH layout.
  localparam int EFLAGS_CF = 0;
  localparam int EFLAGS_PF = 2;
  localparam int EFLAGS_AF = 4;
  localparam int EFLAGS_ZF = 6;
  localparam int EFLAGS_SF = 7;
  localparam int EFLAGS_DF = 10;
  localparam int EFLAGS_OF = 11;

  // Fixed bits of the LAHF byte.
  localparam int LAHF_ONE_BIT   = 1;
  localparam int LAHF_ZERO_BIT3 = 3;
  localparam int LAHF_ZERO_BIT5 = 5;

  typedef enum logic [1:0] {
    WB_LANE_DWORD = 2'd0,
    WB_LANE_WORD  = 2'd1,
    WB_LANE_BYTE  = 2'd2,
    WB_LANE_HBYTE = 2'd3
  } wb_lane_e;

  typedef struct packed {
    logic [2:0]        reg_idx;
    logic              reg_wr;
    wb_lane_e          lane;
    logic [31:0]       result;
    logic              ah_wr;
    logic [STAT_W-1:0] status;
    logic              status_wr;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_TWO   = 2'd2
  } sb_state_e;

  // AH = {SF,ZF,0,AF,0,PF,1,CF}; DF and OF have no place in AH.
  function automatic logic [7:0] lahf_byte(input logic [STAT_W-1:0] s);
    logic [7:0] ah;
    ah                 = '0;
    ah[EFLAGS_CF]      = s[STAT_CF];
    ah[LAHF_ONE_BIT]   = 1'b1;
    ah[EFLAGS_PF]      = s[STAT_PF];
    ah[LAHF_ZERO_BIT3] = 1'b0;
    ah[EFLAGS_AF]      = s[STAT_AF];
    ah[LAHF_ZERO_BIT5] = 1'b0;
    ah[EFLAGS_ZF]      = s[STAT_ZF];
    ah[EFLAGS_SF]      = s[STAT_SF];
    return ah;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// 2-entry in-order FIFO with EMPTY/ONE/TWO occupancy FSM; entry 0 is always the head.
// Latency: pushed data is visible on head_dat the cycle after the push edge.
// Backpressure: full in TWO; push while full and pop while empty are ignored.
// Ports: clk, rst (async, active-high); push/push_dat in; pop in;
//        full, head_vld/head_dat, tail_vld/tail_dat (second entry, valid in TWO) out.
module wb_skid_buf
  import writeback_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         tail_vld,
  output logic [W-1:0] tail_dat
);

  sb_state_e    state_q, state_d;
  logic [W-1:0] ent0_q, ent1_q;
  logic         push_ok, pop_ok;

  assign full     = (state_q == SB_TWO);
  assign head_vld = (state_q != SB_EMPTY);
  assign tail_vld = full;
  assign head_dat = ent0_q;
  assign tail_dat = ent1_q;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & head_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SB_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_EMPTY: if (push_ok) state_d = SB_ONE;
      SB_ONE: begin
        if (push_ok && !pop_ok)      state_d = SB_TWO;
        else if (pop_ok && !push_ok) state_d = SB_EMPTY;
      end
      SB_TWO:   if (pop_ok) state_d = SB_ONE;
      default:  state_d = SB_EMPTY;
    endcase
  end

  // Shift-register storage: popping moves entry 1 down; in ONE a simultaneous
  // push and pop overwrites the head directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      case (state_q)
        SB_EMPTY: if (push_ok) ent0_q <= push_dat;
        SB_ONE: begin
          if (push_ok && pop_ok) ent0_q <= push_dat;
          else if (push_ok)      ent1_q <= push_dat;
        end
        SB_TWO:   if (pop_ok) ent0_q <= ent1_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/writeback.sv
// Retire stage: buffers execute results, commits them in order to the GPR port and status register.
// Latency: result accepted at edge N drives rf_wr_* in cycle N+1; status_q updates at edge N+1.
// Backpressure: in_ready low when the 2-entry buffer is full; rf_stall holds the head.
// Ports: clk, rst; in_valid/in_ready + in_* execute result; rf_stall in;
//        rf_wr_en/idx/be/data GPR write; status_q, status_fwd, retire_cnt out.
// Option: WB_STATUS_FWD_EN forwards pending status; otherwise flag producers are serialised.
module writeback
  import writeback_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_reg_idx,
  input  logic              in_reg_wr,
  input  logic [1:0]        in_lane,
  input  logic [31:0]       in_result,
  input  logic              in_ah_wr,
  input  logic [STAT_W-1:0] in_status,
  input  logic              in_status_wr,
  input  logic              rf_stall,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_idx,
  output logic [3:0]        rf_wr_be,
  output logic [31:0]       rf_wr_data,
  output logic [STAT_W-1:0] status_q,
  output logic [STAT_W-1:0] status_fwd,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int EW = $bits(wb_entry_t);

  wb_entry_t   in_ent, head, tail;
  logic [EW-1:0] head_dat, tail_dat;
  logic        sb_full, head_vld, tail_vld;
  logic        accept, commit;

  always_comb begin
    in_ent           = '0;
    in_ent.reg_idx   = in_reg_idx;
    in_ent.reg_wr    = in_reg_wr;
    in_ent.lane      = wb_lane_e'(in_lane);
    in_ent.result    = in_result;
    in_ent.ah_wr     = in_ah_wr;
    in_ent.status    = in_status;
    in_ent.status_wr = in_status_wr;
  end

  assign head   = wb_entry_t'(head_dat);
  assign tail   = wb_entry_t'(tail_dat);
  assign accept = in_valid & in_ready;
  assign commit = head_vld & ~rf_stall;

  wb_skid_buf #(.W(EW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (in_ent),
    .pop      (commit),
    .full     (sb_full),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .tail_vld (tail_vld),
    .tail_dat (tail_dat)
  );

`ifdef WB_STATUS_FWD_EN
  assign in_ready = ~sb_full;

  // Youngest pending status wins; tail is younger than head.
  always_comb begin
    status_fwd = status_q;
    if (tail_vld && tail.status_wr)      status_fwd = tail.status;
    else if (head_vld && head.status_wr) status_fwd = head.status;
  end
`else
  // Without forwarding, a pending flag producer blocks the next instruction
  // so consumers always read flags from status_q.
  assign in_ready   = ~sb_full & ~((head_vld & head.status_wr) | (tail_vld & tail.status_wr));
  assign status_fwd = status_q;
`endif

  // Lane / LAHF formatting of the head entry; everything is zero unless writing.
  always_comb begin
    rf_wr_en   = commit & (head.reg_wr | head.ah_wr);
    rf_wr_idx  = '0;
    rf_wr_be   = '0;
    rf_wr_data = '0;
    if (rf_wr_en) begin
      if (head.ah_wr) begin
        rf_wr_idx  = 3'd0;
        rf_wr_be   = 4'b0010;
        rf_wr_data = {16'b0, lahf_byte(head.status), 8'b0};
      end else begin
        rf_wr_idx = head.reg_idx;
        case (head.lane)
          WB_LANE_DWORD: begin
            rf_wr_be   = 4'b1111;
            rf_wr_data = head.result;
          end
          WB_LANE_WORD: begin
            rf_wr_be   = 4'b0011;
            rf_wr_data = {16'b0, head.result[15:0]};
          end
          WB_LANE_BYTE: begin
            rf_wr_be   = 4'b0001;
            rf_wr_data = {24'b0, head.result[7:0]};
          end
          default: begin
            rf_wr_be   = 4'b0010;
            rf_wr_data = {16'b0, head.result[7:0], 8'b0};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      retire_cnt <= '0;
    end else if (commit) begin
      if (head.status_wr) status_q <= head.status;
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: lane formatting, LAHF, stall/skid behaviour,
// reset with a full buffer, and status forwarding vs. serialisation.
// Latency: n/a. Backpressure: exercised through rf_stall.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg_idx;
  logic        in_reg_wr;
  logic [1:0]  in_lane;
  logic [31:0] in_result;
  logic        in_ah_wr;
  logic [6:0]  in_status;
  logic        in_status_wr;
  logic        rf_stall;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_idx;
  logic [3:0]  rf_wr_be;
  logic [31:0] rf_wr_data;
  logic [6:0]  status_q;
  logic [6:0]  status_fwd;
  logic [15:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  writeback #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_idx   (in_reg_idx),
    .in_reg_wr    (in_reg_wr),
    .in_lane      (in_lane),
    .in_result    (in_result),
    .in_ah_wr     (in_ah_wr),
    .in_status    (in_status),
    .in_status_wr (in_status_wr),
    .rf_stall     (rf_stall),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_idx    (rf_wr_idx),
    .rf_wr_be     (rf_wr_be),
    .rf_wr_data   (rf_wr_data),
    .status_q     (status_q),
    .status_fwd   (status_fwd),
    .retire_cnt   (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] idx, input logic rw, input logic [1:0] lane,
                       input logic [31:0] res, input logic ah, input logic [6:0] st,
                       input logic sw);
    in_valid     = 1'b1;
    in_reg_idx   = idx;
    in_reg_wr    = rw;
    in_lane      = lane;
    in_result    = res;
    in_ah_wr     = ah;
    in_status    = st;
    in_status_wr = sw;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_reg_idx   = '0;
    in_reg_wr    = 1'b0;
    in_lane      = '0;
    in_result    = '0;
    in_ah_wr     = 1'b0;
    in_status    = '0;
    in_status_wr = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are checked in the low phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [2:0] idx,
                        input logic [3:0] be, input logic [31:0] data);
    chk({tag, "_en"},   32'(rf_wr_en),   32'(en));
    chk({tag, "_idx"},  32'(rf_wr_idx),  32'(idx));
    chk({tag, "_be"},   32'(rf_wr_be),   32'(be));
    chk({tag, "_data"}, rf_wr_data,      data);
  endtask

  initial begin
    rst = 1'b1;
    rf_stall = 1'b0;
    idle();
    @(negedge clk);
    #2;
    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_wr("rst_wr", 1'b0, 3'd0, 4'h0, 32'h0);
    chk("rst_status_q", 32'(status_q), 32'h0);
    chk("rst_status_fwd", 32'(status_fwd), 32'h0);
    chk("rst_cnt", 32'(retire_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Single dword write
    drive(3'd3, 1'b1, 2'd0, 32'hDEADBEEF, 1'b0, 7'h00, 1'b0);
    step();
    idle();
    #2;
    chk_wr("dword", 1'b1, 3'd3, 4'hF, 32'hDEADBEEF);
    step();
    exp_cnt = 1;
    chk("dword_cnt", 32'(retire_cnt), 32'(exp_cnt));
    chk("dword_idle_en", 32'(rf_wr_en), 32'd0);

    // LAHF: CF,PF,ZF,SF set -> AH = 0xC7; idx/lane/reg_wr are overridden
    drive(3'd5, 1'b0, 2'd1, 32'hFFFFFFFF, 1'b1, 7'b0011110, 1'b0);
    step();
    idle();
    #2;
    chk_wr("lahf", 1'b1, 3'd0, 4'b0010, 32'h0000C700);
    step();
    exp_cnt = 2;
    chk("lahf_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Flag producer
    drive(3'd1, 1'b1, 2'd0, 32'h1, 1'b0, 7'h15, 1'b1);
    step();
    idle();
    #2;
`ifdef WB_STATUS_FWD_EN
    chk("flag_pend_ready", 32'(in_ready), 32'd1);
    chk("flag_pend_fwd", 32'(status_fwd), 32'h15);
`else
    chk("flag_pend_ready", 32'(in_ready), 32'd0);
    chk("flag_pend_fwd", 32'(status_fwd), 32'h00);
`endif
    chk("flag_pend_status_q", 32'(status_q), 32'h00);
    chk("flag_en", 32'(rf_wr_en), 32'd1);
    step();
    exp_cnt = 3;
    chk("flag_status_q", 32'(status_q), 32'h15);
    chk("flag_status_fwd", 32'(status_fwd), 32'h15);
    chk("flag_ready", 32'(in_ready), 32'd1);
    chk("flag_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // High byte lane; status ignored since status_wr = 0
    drive(3'd6, 1'b1, 2'd3, 32'hFFFFFF5A, 1'b0, 7'h7F, 1'b0);
    step();
    idle();
    #2;
    chk_wr("hbyte", 1'b1, 3'd6, 4'b0010, 32'h00005A00);
    step();
    exp_cnt = 4;
    chk("hbyte_status_q", 32'(status_q), 32'h15);
    chk("hbyte_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Word then byte back to back (accept + commit in ONE)
    drive(3'd2, 1'b1, 2'd1, 32'hCAFEF00D, 1'b0, 7'h00, 1'b0);
    step();
    drive(3'd4, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 7'h00, 1'b0);
    #2;
    chk_wr("word", 1'b1, 3'd2, 4'b0011, 32'h0000F00D);
    chk("word_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    #2;
    chk_wr("byte", 1'b1, 3'd4, 4'b0001, 32'h0000000D);
    step();
    exp_cnt = 6;
    chk("wb_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Stall for 3 cycles while three results are offered
    rf_stall = 1'b1;
    drive(3'd2, 1'b1, 2'd0, 32'h11111111, 1'b0, 7'h00, 1'b0);
    step();
    #2;
    chk("stall1_ready", 32'(in_ready), 32'd1);
    chk("stall1_en", 32'(rf_wr_en), 32'd0);
    drive(3'd2, 1'b1, 2'd0, 32'h22222222, 1'b0, 7'h00, 1'b0);
    step();
    #2;
    chk("stall2_ready", 32'(in_ready), 32'd0);
    chk("stall2_en", 32'(rf_wr_en), 32'd0);
    drive(3'd2, 1'b1, 2'd0, 32'h33333333, 1'b0, 7'h00, 1'b0);
    step();
    #2;
    chk("stall3_ready", 32'(in_ready), 32'd0);
    chk("stall3_cnt", 32'(retire_cnt), 32'(exp_cnt));
    rf_stall = 1'b0;
    #2;
    chk_wr("rel_r1", 1'b1, 3'd2, 4'hF, 32'h11111111);
    step();
    #2;
    exp_cnt = 7;
    chk_wr("rel_r2", 1'b1, 3'd2, 4'hF, 32'h22222222);
    chk("rel_r2_ready", 32'(in_ready), 32'd1);
    chk("rel_r2_cnt", 32'(retire_cnt), 32'(exp_cnt));
    step();
    idle();
    #2;
    exp_cnt = 8;
    chk_wr("rel_r3", 1'b1, 3'd2, 4'hF, 32'h33333333);
    chk("rel_r3_cnt", 32'(retire_cnt), 32'(exp_cnt));
    step();
    exp_cnt = 9;
    chk("rel_done_cnt", 32'(retire_cnt), 32'(exp_cnt));
    chk("rel_done_en", 32'(rf_wr_en), 32'd0);

    // Reset with the buffer full
    rf_stall = 1'b1;
    drive(3'd7, 1'b1, 2'd0, 32'hAAAAAAAA, 1'b0, 7'h00, 1'b0);
    step();
    drive(3'd7, 1'b1, 2'd0, 32'hBBBBBBBB, 1'b0, 7'h00, 1'b0);
    step();
    #2;
    chk("two_ready", 32'(in_ready), 32'd0);
    idle();
    rf_stall = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_en", 32'(rf_wr_en), 32'd0);
    chk("mid_rst_status_q", 32'(status_q), 32'h0);
    chk("mid_rst_cnt", 32'(retire_cnt), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    #2;
    exp_cnt = 0;
    chk("post_rst_en", 32'(rf_wr_en), 32'd0);
    chk("post_rst_cnt", 32'(retire_cnt), 32'(exp_cnt));

    // Set all flags, then a CLC-style entry behind a stall
    drive(3'd0, 1'b0, 2'd0, 32'h0, 1'b0, 7'h7F, 1'b1);
    step();
    idle();
    step();
    exp_cnt = 1;
    chk("setf_status_q", 32'(status_q), 32'h7F);
    chk("setf_cnt", 32'(retire_cnt), 32'(exp_cnt));
    rf_stall = 1'b1;
    drive(3'd0, 1'b0, 2'd0, 32'h0, 1'b0, 7'h00, 1'b1);
    step();
    idle();
    #2;
    chk("clc_en", 32'(rf_wr_en), 32'd0);
    chk("clc_status_q", 32'(status_q), 32'h7F);
`ifdef WB_STATUS_FWD_EN
    chk("clc_fwd", 32'(status_fwd), 32'h00);
    chk("clc_ready", 32'(in_ready), 32'd1);
    // Second flag producer: youngest pending status is forwarded
    drive(3'd0, 1'b0, 2'd0, 32'h0, 1'b0, 7'h2A, 1'b1);
    step();
    idle();
    #2;
    chk("young_fwd", 32'(status_fwd), 32'h2A);
    chk("young_ready", 32'(in_ready), 32'd0);
    rf_stall = 1'b0;
    step();
    exp_cnt = 2;
    chk("clc_commit_status_q", 32'(status_q), 32'h00);
    chk("clc_commit_fwd", 32'(status_fwd), 32'h2A);
    chk("clc_commit_cnt", 32'(retire_cnt), 32'(exp_cnt));
    step();
    exp_cnt = 3;
    chk("young_status_q", 32'(status_q), 32'h2A);
    chk("young_cnt", 32'(retire_cnt), 32'(exp_cnt));
`else
    chk("clc_fwd", 32'(status_fwd), 32'h7F);
    chk("clc_ready", 32'(in_ready), 32'd0);
    step();
    #2;
    chk("clc_hold_ready", 32'(in_ready), 32'd0);
    chk("clc_hold_status_q", 32'(status_q), 32'h7F);
    rf_stall = 1'b0;
    step();
    exp_cnt = 2;
    chk("clc_commit_status_q", 32'(status_q), 32'h00);
    chk("clc_commit_fwd", 32'(status_fwd), 32'h00);
    chk("clc_commit_ready", 32'(in_ready), 32'd1);
    chk("clc_commit_cnt", 32'(retire_cnt), 32'(exp_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
